// File: rtl/jtframe_ioctl_pkg.sv
// Shared definitions for the HPS ioctl upload reader: FSM states and the
// HPS-side address width.
package jtframe_ioctl_pkg;

  localparam int HPS_AW = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_GAP  = 2'd2,
    ST_HI   = 2'd3
  } upl_state_e;

endpackage

// File: rtl/jtframe_ioctl_upload_if.sv
// HPS ioctl upload bus plus the core-memory byte read port it drives.
interface jtframe_ioctl_upload_if
  import jtframe_ioctl_pkg::*;
#(
  parameter int AW = 25
);
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [HPS_AW-1:0] ioctl_addr;
  logic [15:0]       ioctl_din;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_dout;
  logic              mem_ok;
  logic              busy;
  logic              ovf;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_dout, mem_ok,
    output ioctl_din, mem_addr, mem_rd, busy, ovf
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_dout, mem_ok,
    input  ioctl_din, mem_addr, mem_rd, busy, ovf
  );
endinterface

// File: rtl/jtframe_ioctl_upload.sv
// HPS upload reader: each ioctl_rd fetches one (WIDE=0) or two (WIDE=1)
// bytes from core memory and publishes them atomically on ioctl_din.
module jtframe_ioctl_upload
  import jtframe_ioctl_pkg::*;
#(
  parameter int WIDE = 1,
  parameter int AW   = 25
) (
  input  logic clk_rom,
  input  logic rst,
  jtframe_ioctl_upload_if.slave bus
);

  upl_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, base;
  logic [7:0]    shadow_q, shadow_d;
  logic [15:0]   din_q, din_d;
  logic          ovf_q, ovf_d;
  logic          busy;

  generate
    if (AW < HPS_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.ioctl_addr[HPS_AW-1:AW];
    end
  endgenerate

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    din_d    = din_q;
    ovf_d    = ovf_q;
    if (!bus.ioctl_upload) begin
      // Session closed: abandon any fetch, keep the last word
      state_d = ST_IDLE;
      ovf_d   = 1'b0;
    end else begin
      if (bus.ioctl_rd && busy) ovf_d = 1'b1;
      case (state_q)
        ST_IDLE: if (bus.ioctl_rd) begin
          addr_d  = bus.ioctl_addr[AW-1:0];
          state_d = ST_LO;
        end
        ST_LO: if (bus.mem_ok) begin
          shadow_d = bus.mem_dout;
          if (WIDE != 0) begin
            state_d = ST_GAP;
          end else begin
            din_d   = {8'h00, bus.mem_dout};
            state_d = ST_IDLE;
          end
        end
        ST_GAP: state_d = ST_HI;
        ST_HI: if (bus.mem_ok) begin
          din_d   = {bus.mem_dout, shadow_q};
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      shadow_q <= '0;
      din_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      din_q    <= din_d;
      ovf_q    <= ovf_d;
    end
  end

  // Low byte sits at the even address in 16-bit mode
  assign base         = (WIDE != 0) ? (addr_q & ~AW'(1)) : addr_q;
  assign bus.mem_addr = base | AW'(state_q == ST_HI);
  assign bus.mem_rd   = (state_q == ST_LO) || (state_q == ST_HI);
  assign bus.ioctl_din = din_q;
  assign bus.busy      = busy;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_jtframe_ioctl_upload.sv
// Bench for jtframe_ioctl_upload: phase-timing model for the 16-bit unit,
// directed literal checks for both widths.
module tb_jtframe_ioctl_upload;

  localparam int AW    = 25;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst;
  logic inj_ok;
  int   lat;
  int   cnt_a, cnt_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:1023];

  // model of the WIDE=1 unit
  logic       m_act = 1'b0;
  int         m_p   = 0;
  int         m_lat = 0;
  logic [9:0] m_addr = '0;
  logic [15:0] m_din = '0;
  logic       m_ovf = 1'b0;
  logic       exp_rd;

  jtframe_ioctl_upload_if #(.AW(AW)) ba ();
  jtframe_ioctl_upload_if #(.AW(AW)) bb ();

  jtframe_ioctl_upload #(.WIDE(1), .AW(AW)) u_a (.clk_rom(clk), .rst(rst), .bus(ba.slave));
  jtframe_ioctl_upload #(.WIDE(0), .AW(AW)) u_b (.clk_rom(clk), .rst(rst), .bus(bb.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Memory for unit A: ack on the (lat+1)-th cycle of a held mem_rd
  always @(negedge clk) begin
    if (inj_ok) begin
      ba.mem_ok = 1'b1; ba.mem_dout = 8'hEE;
    end else if (ba.mem_rd === 1'b1) begin
      if (cnt_a == lat) begin
        ba.mem_ok = 1'b1; ba.mem_dout = mem[ba.mem_addr[9:0]];
      end else begin
        ba.mem_ok = 1'b0; ba.mem_dout = 8'hEE;
      end
      cnt_a++;
    end else begin
      cnt_a = 0; ba.mem_ok = 1'b0; ba.mem_dout = 8'hEE;
    end
  end

  always @(negedge clk) begin
    if (bb.mem_rd === 1'b1) begin
      if (cnt_b == LAT_B) begin
        bb.mem_ok = 1'b1; bb.mem_dout = mem[bb.mem_addr[9:0]];
      end else begin
        bb.mem_ok = 1'b0; bb.mem_dout = 8'hEE;
      end
      cnt_b++;
    end else begin
      cnt_b = 0; bb.mem_ok = 1'b0; bb.mem_dout = 8'hEE;
    end
  end

  // Word fetch = LO (lat+1) + GAP (1) + HI (lat+1) busy cycles, then the word lands
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_act <= 1'b0; m_p <= 0; m_din <= '0; m_ovf <= 1'b0; m_addr <= '0;
    end else if (!ba.ioctl_upload) begin
      m_act <= 1'b0; m_ovf <= 1'b0;
    end else if (m_act) begin
      if (ba.ioctl_rd) m_ovf <= 1'b1;
      if (m_p == 2 * m_lat + 3) begin
        m_din <= {mem[m_addr | 10'd1], mem[m_addr & 10'h3FE]};
        m_act <= 1'b0;
      end else begin
        m_p <= m_p + 1;
      end
    end else if (ba.ioctl_rd) begin
      m_act <= 1'b1; m_p <= 1; m_lat <= lat; m_addr <= ba.ioctl_addr[9:0];
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("din", 32'(ba.ioctl_din), 32'(m_din));
      chk("busy", 32'(ba.busy), 32'(m_act));
      chk("ovf", 32'(ba.ovf), 32'(m_ovf));
      exp_rd = m_act && (m_p != m_lat + 2);
      chk("mem_rd", 32'(ba.mem_rd), 32'(exp_rd));
      if (exp_rd)
        chk("mem_addr", 32'(ba.mem_addr),
            (m_p <= m_lat + 1) ? 32'(m_addr & 10'h3FE) : 32'(m_addr | 10'h001));
    end
  end

  task automatic issue_a(input logic [26:0] a);
    ba.ioctl_addr = a; ba.ioctl_rd = 1'b1;
    step();
    ba.ioctl_rd = 1'b0;
  endtask

  logic [26:0] w_addr [4] = '{27'h100_0200, 27'h202, 27'h101, 27'h400_0200};
  logic [15:0] w_exp  [4] = '{16'hBEEF, 16'hDEAD, 16'h1234, 16'hBEEF};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[10'h100] = 8'h34; mem[10'h101] = 8'h12;
    mem[10'h102] = 8'h78; mem[10'h103] = 8'h56;
    mem[10'h200] = 8'hEF; mem[10'h201] = 8'hBE;
    mem[10'h202] = 8'hAD; mem[10'h203] = 8'hDE;
    mem[10'h007] = 8'hA5;
    w_addr[0] = 27'h200;
    rst = 1'b1; inj_ok = 1'b0; lat = 1;
    ba.ioctl_upload = 1'b0; ba.ioctl_rd = 1'b0; ba.ioctl_addr = '0;
    bb.ioctl_upload = 1'b0; bb.ioctl_rd = 1'b0; bb.ioctl_addr = '0;
    step(3);
    chk("rst_din", 32'(ba.ioctl_din), 32'h0);
    chk("rst_busy", 32'(ba.busy), 32'h0);
    chk("rst_ovf", 32'(ba.ovf), 32'h0);
    chk("rst_mem_rd", 32'(ba.mem_rd), 32'h0);
    chk("rst_mem_addr", 32'(ba.mem_addr), 32'h0);
    chk("rst_din_b", 32'(bb.ioctl_din), 32'h0);
    rst = 1'b0;
    step();

    // 16-bit word at 0x100, ack on second mem_rd cycle
    ba.ioctl_upload = 1'b1; step();
    issue_a(27'h100);
    chk("w_lo_addr", 32'(ba.mem_addr), 32'h100);
    chk("w_lo_rd", 32'(ba.mem_rd), 32'h1);
    step(2);
    chk("w_gap_rd", 32'(ba.mem_rd), 32'h0);
    step();
    chk("w_hi_addr", 32'(ba.mem_addr), 32'h101);
    chk("w_hi_rd", 32'(ba.mem_rd), 32'h1);
    step();
    chk("w_busy_c5", 32'(ba.busy), 32'h1);
    step();
    chk("w_din_c6", 32'(ba.ioctl_din), 32'h1234);
    step();
    chk("w_busy_c7", 32'(ba.busy), 32'h0);

    // overrun: second strobe two cycles into a fetch
    lat = 2;
    issue_a(27'h102);
    step();
    ba.ioctl_addr = 27'h300; ba.ioctl_rd = 1'b1;
    step();
    ba.ioctl_rd = 1'b0;
    chk("ovf_set", 32'(ba.ovf), 32'h1);
    step(10);
    chk("ovf_word", 32'(ba.ioctl_din), 32'h5678);
    chk("ovf_sticky", 32'(ba.ovf), 32'h1);
    ba.ioctl_upload = 1'b0; step();
    chk("ovf_clear", 32'(ba.ovf), 32'h0);

    // session dropped during the high-byte fetch
    ba.ioctl_upload = 1'b1; lat = 1; step();
    issue_a(27'h100);
    step(7);
    chk("drop_prior", 32'(ba.ioctl_din), 32'h1234);
    issue_a(27'h102);
    step(3);
    chk("drop_in_hi", 32'(ba.mem_addr), 32'h103);
    ba.ioctl_upload = 1'b0; step();
    chk("drop_rd", 32'(ba.mem_rd), 32'h0);
    chk("drop_busy", 32'(ba.busy), 32'h0);
    chk("drop_din", 32'(ba.ioctl_din), 32'h1234);

    // reset during LO, then stray acks while idle
    ba.ioctl_upload = 1'b1; lat = 3; step();
    issue_a(27'h100);
    chk("rlo_busy", 32'(ba.busy), 32'h1);
    rst = 1'b1; step();
    chk("rlo_din", 32'(ba.ioctl_din), 32'h0);
    chk("rlo_rd", 32'(ba.mem_rd), 32'h0);
    chk("rlo_busy0", 32'(ba.busy), 32'h0);
    chk("rlo_addr", 32'(ba.mem_addr), 32'h0);
    rst = 1'b0; inj_ok = 1'b1; step(2); inj_ok = 1'b0; step();
    chk("stray_ok_din", 32'(ba.ioctl_din), 32'h0);
    chk("stray_ok_busy", 32'(ba.busy), 32'h0);
    ba.ioctl_upload = 1'b0; ba.ioctl_rd = 1'b1; step(2); ba.ioctl_rd = 1'b0;
    chk("noupl_busy", 32'(ba.busy), 32'h0);
    chk("noupl_ovf", 32'(ba.ovf), 32'h0);

    // spaced words with random memory latency
    ba.ioctl_upload = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      lat = $urandom_range(0, 5);
      issue_a(w_addr[k]);
      step(99);
      chk($sformatf("word%0d", k), 32'(ba.ioctl_din), 32'(w_exp[k]));
    end
    chk("words_ovf", 32'(ba.ovf), 32'h0);

    // 8-bit unit: single fetch, odd address kept
    bb.ioctl_upload = 1'b1; step();
    bb.ioctl_addr = 27'h7; bb.ioctl_rd = 1'b1; step(); bb.ioctl_rd = 1'b0;
    chk("b_addr", 32'(bb.mem_addr), 32'h7);
    chk("b_rd1", 32'(bb.mem_rd), 32'h1);
    step();
    chk("b_rd2", 32'(bb.mem_rd), 32'h1);
    step();
    chk("b_din", 32'(bb.ioctl_din), 32'h00A5);
    chk("b_busy", 32'(bb.busy), 32'h0);
    chk("b_rd_done", 32'(bb.mem_rd), 32'h0);
    chk("b_ovf", 32'(bb.ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_ioctl_upload.md
JTFRAME_IOCTL_UPLOAD -- requirements
Module: jtframe_ioctl_upload

Purpose: serve HPS upload reads (NVRAM/high-score save) by fetching bytes from core memory, packing 16-bit words for hps_io ioctl_din.

Interface
REQ-001 Parameter WIDE, default 1, meaning 1 = 16-bit HPS bus (two byte fetches per word), 0 = 8-bit bus (one fetch).
REQ-002 Parameter AW, default 25, meaning core memory byte-address width.
REQ-003 clk_rom  in  1  clock for all logic; one clock, no other clock domains.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ioctl_upload  in  1  HPS upload session active.
REQ-006 ioctl_rd  in  1  HPS read strobe, one cycle per word.
REQ-007 ioctl_addr  in  27  HPS byte address, even when WIDE=1.
REQ-008 ioctl_din  out  16  word returned to HPS.
REQ-009 mem_addr  out  AW  core memory byte address.
REQ-010 mem_rd  out  1  core memory read request, level, held until mem_ok.
REQ-011 mem_dout  in  8  core memory read data, valid with mem_ok.
REQ-012 mem_ok  in  1  core memory read acknowledge, one cycle.
REQ-013 busy  out  1  high while fetching a word.
REQ-014 ovf  out  1  sticky overrun flag.

Function
REQ-015 FSM states IDLE, LO, GAP, HI; WIDE=0 uses IDLE and LO only.
REQ-016 IDLE: ioctl_rd=1 and ioctl_upload=1 -> latch ioctl_addr[AW-1:0], enter LO next cycle.
REQ-017 LO: mem_rd=1, mem_addr = latched address with bit0 forced 0 (WIDE=1) or unchanged (WIDE=0).
REQ-018 LO with mem_ok=1: capture mem_dout into low shadow byte; WIDE=1 -> GAP, WIDE=0 -> IDLE.
REQ-019 GAP: mem_rd=0 for exactly one cycle so the memory sees a fresh request edge, then HI.
REQ-020 HI: mem_rd=1, mem_addr bit0 = 1; on mem_ok -> IDLE.
REQ-021 ioctl_din updates only on final mem_ok: WIDE=1 -> {mem_dout, shadow}; WIDE=0 -> {8'h00, mem_dout}; never partially updated.
REQ-022 Latency: mem_rd rises cycle after ioctl_rd; with mem_ok k cycles after mem_rd rises, WIDE=1 word ready 2k+2 cycles after ioctl_rd.
REQ-023 mem_ok outside LO/HI is ignored.
REQ-024 busy = (state != IDLE); mem_rd low in IDLE and GAP.
REQ-025 ioctl_rd while busy: request ignored, ovf set; ovf cleared only while ioctl_upload=0 or on rst.
REQ-026 ioctl_upload falling mid-fetch: next cycle state IDLE, mem_rd=0, ioctl_din keeps previous word.
REQ-027 ioctl_rd with ioctl_upload=0: ignored, no ovf.
REQ-028 Address bits above AW are ignored; no wrap detection.

Reset
REQ-029 On rst: state IDLE, ioctl_din=16'h0000, mem_addr=0, mem_rd=0, busy=0, ovf=0, shadow byte=0.
REQ-030 rst mid-fetch aborts identically to REQ-029 in the same cycle; no memory request survives.

Structure
REQ-031 State enum and the 27-bit HPS address width constant SHALL live in shared package jtframe_ioctl_pkg.
REQ-032 Single flat module; no sub-module is natural.

Verification
REQ-033 WIDE=1, mem_ok 2 cycles after mem_rd, bytes 0x34@0x100, 0x12@0x101, ioctl_rd addr 0x100 -> mem_addr 0x100 then 0x101, one-cycle mem_rd gap, ioctl_din=0x1234 at cycle 6, busy low cycle 7.
REQ-034 WIDE=0, byte 0xA5@0x7, ioctl_rd addr 0x7 -> single fetch, ioctl_din=0x00A5, no GAP.
REQ-035 ioctl_rd repeated 2 cycles after first (WIDE=1) -> second ignored, ovf=1; drop ioctl_upload -> ovf=0.
REQ-036 ioctl_upload dropped during HI -> mem_rd=0 next cycle, ioctl_din keeps prior 0x1234, state IDLE.
REQ-037 rst asserted during LO -> all outputs at reset values same cycle, later mem_ok ignored.
REQ-038 Back-to-back words 0x200, 0x202 spaced 100 cycles, mem_ok latency 0..5 random -> each ioctl_din matches memory model, ovf stays 0.
